// File: rtl/program_loader.sv
// Program loader: streams a program image into a core's instruction memory,
// then holds the core in reset for one PRIME cycle and runs it for a cycle budget.
module program_loader #(
    parameter int PC_W      = 10,
    parameter int MAX_WORDS = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic [8:0]      prog_len,
    input  logic [PC_W-1:0] entry_pc,
    input  logic [15:0]     run_cycles,
    input  logic            s_valid,
    input  logic [31:0]     s_data,
    output logic            s_ready,
    output logic            instr_we,
    output logic [31:0]     instr_feed,
    output logic [7:0]      instr_addr,
    output logic [PC_W-1:0] init_pc,
    output logic            core_rst,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        PRIME = 3'd2,
        RUN   = 3'd3,
        HALT  = 3'd4
    } state_t;

    localparam logic [9:0] LP_MAX = 10'(MAX_WORDS);

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_reject;
    logic            w_hs;
    logic            w_len_ok;

    logic [8:0]      r_len;
    logic [PC_W-1:0] r_entry;
    logic [15:0]     r_cycles;
    logic [8:0]      r_count;
    logic [15:0]     r_run_cnt;

    logic            r_s_ready;
    logic            r_instr_we;
    logic [31:0]     r_instr_feed;
    logic [7:0]      r_instr_addr;
    logic [PC_W-1:0] r_init_pc;
    logic            r_core_rst;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    assign w_len_ok = (prog_len != 9'd0) && ({1'b0, prog_len} <= LP_MAX);
    // Abort suppresses any handshake in the same cycle.
    assign w_hs     = s_valid & r_s_ready & ~abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_reject = 1'b0;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        if (w_len_ok) begin
                            w_next   = LOAD;
                            w_accept = 1'b1;
                        end else begin
                            w_next   = IDLE;
                            w_reject = 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_hs && (r_count == r_len - 9'd1)) begin
                        w_next = PRIME;
                    end
                end
                PRIME: w_next = RUN;
                RUN: begin
                    if ((r_cycles != 16'd0) && (r_run_cnt == r_cycles - 16'd1)) begin
                        w_next = HALT;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len        <= '0;
            r_entry      <= '0;
            r_cycles     <= '0;
            r_count      <= '0;
            r_run_cnt    <= '0;
            r_s_ready    <= 1'b0;
            r_instr_we   <= 1'b0;
            r_instr_feed <= '0;
            r_instr_addr <= '0;
            r_init_pc    <= '0;
            r_core_rst   <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_s_ready  <= (w_next == LOAD);
            r_core_rst <= (w_next != RUN);
            r_busy     <= (w_next == LOAD) || (w_next == PRIME) || (w_next == RUN);
            r_done     <= (w_next == HALT);
            r_instr_we <= w_hs;
            if (w_hs) begin
                r_instr_feed <= s_data;
                r_instr_addr <= r_count[7:0];
                r_count      <= r_count + 9'd1;
            end
            if (w_accept) begin
                r_len    <= prog_len;
                r_entry  <= entry_pc;
                r_cycles <= run_cycles;
                r_count  <= '0;
                r_err    <= 1'b0;
            end
            if (w_reject) begin
                r_err <= 1'b1;
            end
            if ((r_state == LOAD) && (w_next == PRIME)) begin
                r_init_pc <= r_entry;
            end
            if ((r_state == RUN) && (w_next == RUN)) begin
                r_run_cnt <= r_run_cnt + 16'd1;
            end else begin
                r_run_cnt <= '0;
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign instr_we   = r_instr_we;
    assign instr_feed = r_instr_feed;
    assign instr_addr = r_instr_addr;
    assign init_pc    = r_init_pc;
    assign core_rst   = r_core_rst;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
